nw_fifo_v: RTL and testbench

NW_FIFO_V -- requirements
Module: nw_fifo_v

---
 rtl/nw_fifo_v_pkg.sv | 24 ++
 rtl/nw_fifo_v_mem.sv | 46 ++++
 rtl/nw_fifo_v.sv | 152 +++++++++++++++
 tb/tb_nw_fifo_v.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/nw_fifo_v_pkg.sv
// Shared NW FIFO package: flag bundle type and the occupancy-to-flags decode
// used for both the reset value and the next-state value of the flag register.
package nw_fifo_v_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic nearly_full;
    logic nearly_empty;
    logic fast_empty;
  } fifov_flags_t;

  // Flags for a given occupancy out of a given depth.
  function automatic fifov_flags_t flags_from_occ(int unsigned occ, int unsigned depth);
    fifov_flags_t f;
    f.full         = (occ == depth);
    f.empty        = (occ == 0);
    f.nearly_full  = (occ == depth - 1);
    f.nearly_empty = (occ == 1);
    f.fast_empty   = (occ == 0);
    return f;
  endfunction

endpackage

// File: rtl/nw_fifo_v_mem.sv
// Storage array for nw_fifo_v: one write port, one asynchronous read port.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   we, waddr, wdata  write enable / address / data
//   raddr, rdata_c    read address and combinational read data
// On reset the array is cleared, or (init_fifo_contents=1) entry i is loaded
// with a one-hot word with bit i set for i = 0..size-2.
module nw_fifo_v_mem
  import nw_fifo_v_pkg::*;
#(
  parameter int unsigned dsize              = 4,
  parameter int unsigned size               = 5,
  parameter int unsigned init_fifo_contents = 0,
  parameter int unsigned addr_w             = $clog2(size)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [addr_w-1:0] waddr,
  input  logic [dsize-1:0]  wdata,
  input  logic [addr_w-1:0] raddr,
  output logic [dsize-1:0]  rdata_c
);

  logic [dsize-1:0] mem_q [size];

  // Reset content of one entry.
  function automatic logic [dsize-1:0] reset_word(int unsigned idx);
    logic [dsize-1:0] one;
    one = dsize'(1);
    if (init_fifo_contents != 0 && idx + 1 < size && idx < dsize) return one << idx;
    return '0;
  endfunction

  // Storage write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < size; i++) mem_q[i] <= reset_word(i);
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/nw_fifo_v.sv
// nw_fifo_v: synchronous FIFO with registered flags, optional input register,
// optional head register and optional reset preload of one-hot ids.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   push, pop   write / remove-head requests
//   data_in     write data (dsize bits)
//   data_out    head entry (dsize bits)
//   flags       fifov_flags_t {full, empty, nearly_full, nearly_empty, fast_empty}
// Optional build macro NW_FIFO_V_CHECKS_EN: simulation-only checks that stop
// the run on push while full without pop, and on pop while empty.
module nw_fifo_v
  import nw_fifo_v_pkg::*;
#(
  parameter int unsigned dsize              = 4,
  parameter int unsigned size               = 5,
  parameter int unsigned init_fifo_contents = 0,
  parameter int unsigned input_reg          = 0,
  parameter int unsigned output_reg         = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [dsize-1:0] data_in,
  output logic [dsize-1:0] data_out,
  output fifov_flags_t     flags
);

  localparam int unsigned addr_w  = $clog2(size);
  localparam int unsigned cnt_w   = $clog2(size + 1);
  localparam int unsigned occ_rst = (init_fifo_contents != 0) ? size - 1 : 0;
  localparam fifov_flags_t flags_rst = flags_from_occ(occ_rst, size);

  logic              push_w;
  logic [dsize-1:0]  data_w;
  logic              do_push;
  logic              do_pop;
  logic [addr_w-1:0] wr_ptr_q, wr_ptr_nxt;
  logic [addr_w-1:0] rd_ptr_q, rd_ptr_nxt, rd_ptr_inc;
  logic [cnt_w-1:0]  occ_q, occ_nxt;
  fifov_flags_t      flags_q, flags_nxt;
  logic [addr_w-1:0] mem_raddr;
  logic [dsize-1:0]  mem_rdata_c;

  // Optional input stage: push and data delayed one cycle before the write.
  if (input_reg != 0) begin : g_in_reg
    logic             push_q;
    logic [dsize-1:0] data_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        push_q <= 1'b0;
        data_q <= '0;
      end else begin
        push_q <= push;
        data_q <= data_in;
      end
    end
    assign push_w = push_q;
    assign data_w = data_q;
  end else begin : g_in_direct
    assign push_w = push;
    assign data_w = data_in;
  end

  // Accept logic, pointer advance with wrap, occupancy and flag next state.
  // A push on a full FIFO is only taken when the head is popped in the same cycle.
  always_comb begin
    do_pop     = pop & ~flags_q.empty;
    do_push    = push_w & (~flags_q.full | do_pop);
    rd_ptr_inc = (rd_ptr_q == addr_w'(size - 1)) ? '0 : rd_ptr_q + addr_w'(1);
    rd_ptr_nxt = do_pop ? rd_ptr_inc : rd_ptr_q;
    wr_ptr_nxt = wr_ptr_q;
    if (do_push) wr_ptr_nxt = (wr_ptr_q == addr_w'(size - 1)) ? '0 : wr_ptr_q + addr_w'(1);
    occ_nxt    = occ_q + cnt_w'(do_push) - cnt_w'(do_pop);
    flags_nxt  = flags_from_occ(32'(occ_nxt), size);
  end

  // State registers. With a preload the write pointer starts just past the
  // last preloaded entry so the first push cannot overwrite the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= addr_w'(occ_rst);
      rd_ptr_q <= '0;
      occ_q    <= cnt_w'(occ_rst);
      flags_q  <= flags_rst;
    end else begin
      wr_ptr_q <= wr_ptr_nxt;
      rd_ptr_q <= rd_ptr_nxt;
      occ_q    <= occ_nxt;
      flags_q  <= flags_nxt;
    end
  end

  assign flags = flags_q;

  nw_fifo_v_mem #(
    .dsize              (dsize),
    .size               (size),
    .init_fifo_contents (init_fifo_contents),
    .addr_w             (addr_w)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (do_push),
    .waddr   (wr_ptr_q),
    .wdata   (data_w),
    .raddr   (mem_raddr),
    .rdata_c (mem_rdata_c)
  );

  if (output_reg != 0) begin : g_out_reg
    // Head register: looks ahead one entry so it tracks the head after a pop;
    // cleared whenever the FIFO becomes empty.
    logic [dsize-1:0] head_q, head_nxt;
    assign mem_raddr = rd_ptr_inc;
    always_comb begin
      head_nxt = head_q;
      if (occ_nxt == '0) begin
        head_nxt = '0;
      end else if (occ_q == '0 || (occ_q == cnt_w'(1) && do_pop)) begin
        head_nxt = data_w;
      end else if (do_pop) begin
        head_nxt = mem_rdata_c;
      end
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) head_q <= (init_fifo_contents != 0) ? dsize'(1) : '0;
      else        head_q <= head_nxt;
    end
    assign data_out = head_q;
  end else begin : g_out_direct
    assign mem_raddr = rd_ptr_q;
    assign data_out  = mem_rdata_c;
  end

`ifdef NW_FIFO_V_CHECKS_EN
  // Simulation-only protocol checks.
  always @(posedge clk) begin
    if (rst_n) begin
      if (push_w && flags_q.full && !pop) begin
        $error("%0t %m: push while full without pop", $time);
        $finish;
      end
      if (pop && flags_q.empty) begin
        $error("%0t %m: pop while empty", $time);
        $finish;
      end
    end
  end
`endif

endmodule

// File: tb/tb_nw_fifo_v.sv
// Directed bench for nw_fifo_v. Three instances share clock and reset:
//   dut_a: size 5, dsize 4, empty reset, no input/output register
//   dut_b: size 5, dsize 4, preloaded, output register
//   dut_c: size 5, dsize 4, empty reset, input and output register
// Flags are compared as {full, empty, nearly_full, nearly_empty, fast_empty}.
module tb_nw_fifo_v;
  import nw_fifo_v_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic pa = 0, qa = 0, pb = 0, qb = 0, pc = 0, qc = 0;
  logic [3:0] da = '0, db = '0, dc = '0;
  logic [3:0] oa, ob, oc;
  fifov_flags_t fa, fb, fc;

  int total = 0;
  int bad   = 0;

  localparam logic [4:0] f_empty = 5'b01001;
  localparam logic [4:0] f_one   = 5'b00010;
  localparam logic [4:0] f_mid   = 5'b00000;
  localparam logic [4:0] f_nfull = 5'b00100;
  localparam logic [4:0] f_full  = 5'b10000;

  nw_fifo_v #(.dsize(4), .size(5), .init_fifo_contents(0), .input_reg(0), .output_reg(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .push(pa), .pop(qa), .data_in(da), .data_out(oa), .flags(fa));
  nw_fifo_v #(.dsize(4), .size(5), .init_fifo_contents(1), .input_reg(0), .output_reg(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .push(pb), .pop(qb), .data_in(db), .data_out(ob), .flags(fb));
  nw_fifo_v #(.dsize(4), .size(5), .init_fifo_contents(0), .input_reg(1), .output_reg(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .push(pc), .pop(qc), .data_in(dc), .data_out(oc), .flags(fc));

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (fa !== f_empty) begin bad++; $display("FAIL reset_a_flags: got %b want %b", fa, f_empty); end
    total++; if (oa !== 4'b0000) begin bad++; $display("FAIL reset_a_data: got %b want %b", oa, 4'b0000); end
    total++; if (fb !== f_nfull) begin bad++; $display("FAIL reset_b_flags: got %b want %b", fb, f_nfull); end
    total++; if (ob !== 4'b0001) begin bad++; $display("FAIL reset_b_data: got %b want %b", ob, 4'b0001); end
    total++; if (fc !== f_empty) begin bad++; $display("FAIL reset_c_flags: got %b want %b", fc, f_empty); end
    total++; if (oc !== 4'b0000) begin bad++; $display("FAIL reset_c_data: got %b want %b", oc, 4'b0000); end
  endtask

  task automatic test_push_visible();
    // no input register: visible one cycle after the push
    pa = 1; da = 4'b0100;
    @(negedge clk); pa = 0;
    total++; if (fa !== f_one) begin bad++; $display("FAIL push_a_flags: got %b want %b", fa, f_one); end
    total++; if (oa !== 4'b0100) begin bad++; $display("FAIL push_a_data: got %b want %b", oa, 4'b0100); end
    qa = 1;
    @(negedge clk); qa = 0;
    total++; if (fa !== f_empty) begin bad++; $display("FAIL pop_a_flags: got %b want %b", fa, f_empty); end
    // input register: still empty after one cycle, visible after two
    pc = 1; dc = 4'b0100;
    @(negedge clk); pc = 0;
    total++; if (fc !== f_empty) begin bad++; $display("FAIL push_c_early_flags: got %b want %b", fc, f_empty); end
    total++; if (oc !== 4'b0000) begin bad++; $display("FAIL push_c_early_data: got %b want %b", oc, 4'b0000); end
    @(negedge clk);
    total++; if (fc !== f_one) begin bad++; $display("FAIL push_c_flags: got %b want %b", fc, f_one); end
    total++; if (oc !== 4'b0100) begin bad++; $display("FAIL push_c_data: got %b want %b", oc, 4'b0100); end
    qc = 1;
    @(negedge clk); qc = 0;
    total++; if (fc !== f_empty) begin bad++; $display("FAIL pop_c_flags: got %b want %b", fc, f_empty); end
    total++; if (oc !== 4'b0000) begin bad++; $display("FAIL pop_c_zero_data: got %b want %b", oc, 4'b0000); end
  endtask

  task automatic test_pop_empty_push();
    pa = 1; qa = 1; da = 4'b1000;
    @(negedge clk); pa = 0; qa = 0;
    total++; if (fa !== f_one) begin bad++; $display("FAIL pe_push_flags: got %b want %b", fa, f_one); end
    total++; if (oa !== 4'b1000) begin bad++; $display("FAIL pe_push_data: got %b want %b", oa, 4'b1000); end
    qa = 1;
    @(negedge clk); qa = 0;
    total++; if (fa !== f_empty) begin bad++; $display("FAIL pe_drain_flags: got %b want %b", fa, f_empty); end
  endtask

  task automatic test_full();
    logic [3:0] exp_d [4];
    logic [4:0] exp_f [5];
    exp_d[0] = 4'b0011; exp_d[1] = 4'b0100; exp_d[2] = 4'b0101; exp_d[3] = 4'b0011;
    exp_f[0] = f_nfull; exp_f[1] = f_mid; exp_f[2] = f_mid; exp_f[3] = f_one; exp_f[4] = f_empty;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        total++; if (fa !== f_nfull) begin bad++; $display("FAIL fill4_flags: got %b want %b", fa, f_nfull); end
      end
      pa = 1; da = 4'(i + 1);
      @(negedge clk);
    end
    pa = 0;
    total++; if (fa !== f_full) begin bad++; $display("FAIL fill5_flags: got %b want %b", fa, f_full); end
    total++; if (oa !== 4'b0001) begin bad++; $display("FAIL fill5_head: got %b want %b", oa, 4'b0001); end
    // push with pop while full: both accepted
    pa = 1; qa = 1; da = 4'b0011;
    @(negedge clk); pa = 0; qa = 0;
    total++; if (fa !== f_full) begin bad++; $display("FAIL full_pp_flags: got %b want %b", fa, f_full); end
    total++; if (oa !== 4'b0010) begin bad++; $display("FAIL full_pp_head: got %b want %b", oa, 4'b0010); end
    // push without pop while full: dropped
    pa = 1; da = 4'b1111;
    @(negedge clk); pa = 0;
    total++; if (fa !== f_full) begin bad++; $display("FAIL full_drop_flags: got %b want %b", fa, f_full); end
    total++; if (oa !== 4'b0010) begin bad++; $display("FAIL full_drop_head: got %b want %b", oa, 4'b0010); end
    qa = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) qa = 0;
      total++; if (fa !== exp_f[i]) begin bad++; $display("FAIL drain_flags[%0d]: got %b want %b", i, fa, exp_f[i]); end
      if (i < 4) begin
        total++; if (oa !== exp_d[i]) begin bad++; $display("FAIL drain_data[%0d]: got %b want %b", i, oa, exp_d[i]); end
      end
    end
  endtask

  task automatic test_preload_pops();
    logic [3:0] exp_d [4];
    logic [4:0] exp_f [4];
    exp_d[0] = 4'b0010; exp_d[1] = 4'b0100; exp_d[2] = 4'b1000; exp_d[3] = 4'b0000;
    exp_f[0] = f_mid; exp_f[1] = f_mid; exp_f[2] = f_one; exp_f[3] = f_empty;
    total++; if (ob !== 4'b0001) begin bad++; $display("FAIL preload_head: got %b want %b", ob, 4'b0001); end
    qb = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) qb = 0;
      total++; if (ob !== exp_d[i]) begin bad++; $display("FAIL preload_data[%0d]: got %b want %b", i, ob, exp_d[i]); end
      total++; if (fb !== exp_f[i]) begin bad++; $display("FAIL preload_flags[%0d]: got %b want %b", i, fb, exp_f[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_d [3];
    exp_d[0] = 4'b0010; exp_d[1] = 4'b0011; exp_d[2] = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      pc = 1; dc = 4'(i + 1);
      @(negedge clk);
    end
    pc = 0;
    @(negedge clk);
    total++; if (fc !== f_mid) begin bad++; $display("FAIL b2b_flags: got %b want %b", fc, f_mid); end
    total++; if (oc !== 4'b0001) begin bad++; $display("FAIL b2b_head: got %b want %b", oc, 4'b0001); end
    qc = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) qc = 0;
      total++; if (oc !== exp_d[i]) begin bad++; $display("FAIL b2b_data[%0d]: got %b want %b", i, oc, exp_d[i]); end
    end
    total++; if (fc !== f_empty) begin bad++; $display("FAIL b2b_end_flags: got %b want %b", fc, f_empty); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] vals [3];
    vals[0] = 4'b0110; vals[1] = 4'b0111; vals[2] = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      pb = 1; db = vals[i];
      @(negedge clk);
    end
    pb = 0;
    total++; if (ob !== 4'b0110) begin bad++; $display("FAIL mid_b_head: got %b want %b", ob, 4'b0110); end
    total++; if (fb !== f_mid) begin bad++; $display("FAIL mid_b_flags: got %b want %b", fb, f_mid); end
    // load a push into dut_c's input register, then reset before it is written
    pc = 1; dc = 4'b1010;
    @(posedge clk);
    #2;
    pc = 0;
    rst_n = 1'b0;
    #1;
    total++; if (fb !== f_nfull) begin bad++; $display("FAIL rst_async_b_flags: got %b want %b", fb, f_nfull); end
    total++; if (ob !== 4'b0001) begin bad++; $display("FAIL rst_async_b_data: got %b want %b", ob, 4'b0001); end
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (fc !== f_empty) begin bad++; $display("FAIL rst_c_discard_flags: got %b want %b", fc, f_empty); end
    total++; if (oc !== 4'b0000) begin bad++; $display("FAIL rst_c_discard_data: got %b want %b", oc, 4'b0000); end
    total++; if (fb !== f_nfull) begin bad++; $display("FAIL rst_b_hold_flags: got %b want %b", fb, f_nfull); end
    qb = 1;
    @(negedge clk); qb = 0;
    total++; if (ob !== 4'b0010) begin bad++; $display("FAIL rst_b_reload_data: got %b want %b", ob, 4'b0010); end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_push_visible();
    test_pop_empty_push();
    test_full();
    test_preload_pops();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
